// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Pointer/handshake controller that turns a single-write-port, async-read RAM
// into a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr                   sync clear of pointers, count and error flags
//   in_valid/in_ready     producer handshake, in_data passed to ram_din
//   out_valid/out_ready   consumer handshake, out_data is ram_dout
//   count, almost_full    occupancy 0..DEPTH and high-water flag
//   overflow, underflow   sticky error flags
//   ram_wen, ram_din, ram_addrin, ram_addrout, ram_dout   RAM interface
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_wen,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addrin,
  output logic [ADDR_WIDTH-1:0] ram_addrout,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  // Extra MSB on each pointer is a wrap flag that disambiguates full/empty.
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic                empty, full, push, pop;

  // Status comes from registered state only; no path from in_valid/out_ready.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !clr;
  assign pop       = out_valid && out_ready && !clr;

  assign ram_wen     = push;
  assign ram_din     = in_data;
  assign ram_addrin  = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_addrout = rd_ptr[ADDR_WIDTH-1:0];
  assign out_data    = ram_dout;
  assign almost_full = (count >= AF_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Refused requests only mark the flag; pointers are untouched.
      if (in_valid && full)   overflow  <= 1'b1;
      if (out_ready && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Pointer and handshake controller that sits directly upstream of the team's single-write-port, async-read RAM.
- Turns the RAM into a first-word-fall-through FIFO:
  - generates the RAM write enable, write address and read address;
  - passes write data through to the RAM;
  - presents RAM read data to the consumer under a valid/ready handshake.
- Adds occupancy count, almost-full, and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 8, width of data words; must match the RAM word width.
- ADDR_WIDTH, 3, RAM address width. DEPTH = 2**ADDR_WIDTH entries.
- AF_MARGIN, 1, almost_full asserts when count >= DEPTH - AF_MARGIN. Legal range 0..DEPTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pointers, count and flags.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept a word; equals !full.
- in_data  in  DATA_WIDTH  producer data.
- out_valid  out  1  out_data holds the head word; equals !empty.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_WIDTH  head word, combinationally equal to ram_dout.
- count  out  ADDR_WIDTH+1  occupancy, range 0..DEPTH.
- almost_full  out  1  count >= DEPTH - AF_MARGIN.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- ram_wen  out  1  to RAM wen.
- ram_din  out  DATA_WIDTH  to RAM din; equals in_data.
- ram_addrin  out  ADDR_WIDTH  to RAM addrin; equals wr_ptr[ADDR_WIDTH-1:0].
- ram_addrout  out  ADDR_WIDTH  to RAM addrout; equals rd_ptr[ADDR_WIDTH-1:0].
- ram_dout  in  DATA_WIDTH  from RAM dout.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits (extra bit is the wrap flag);
  - count register;
  - overflow and underflow flags.
- Status decode:
  - empty = (wr_ptr == rd_ptr);
  - full = (MSBs differ) && (low ADDR_WIDTH bits equal).
  - full and empty are registered-state decodes; they never depend combinationally on in_valid or out_ready.
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count, overflow, underflow = 0;
  - hence in_ready=1, out_valid=0, almost_full=(AF_MARGIN>=DEPTH), ram_wen=0.
  - RAM contents are not cleared and are don't-care.
- Push = in_valid && in_ready && !clr.
  - ram_wen = push, combinationally.
  - wr_ptr increments on the clock edge, wrapping modulo 2*DEPTH.
- Pop = out_valid && out_ready && !clr.
  - rd_ptr increments on the clock edge, wrapping modulo 2*DEPTH.
- Latency: a word pushed into an empty FIFO appears with out_valid=1 on the cycle after the push edge. The RAM write lands on that edge and the read is asynchronous.
- count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on push and pop together, or on neither.
  - count always equals wr_ptr - rd_ptr (mod 2*DEPTH).
- Full: in_ready=0, so a concurrent pop proceeds and the push is refused. The push must be re-offered next cycle, when in_ready=1.
- Empty: out_valid=0, so no pop. A push proceeds, and no same-cycle bypass of in_data to out_data occurs.
- Error flags:
  - overflow sets when in_valid && !in_ready;
  - underflow sets when out_ready && !out_valid.
  - Both hold until clr or reset; the offending request has no effect on pointers.
- clr:
  - pointers, count and both flags go to 0 at the next edge;
  - clr forces push=pop=0 (ram_wen=0) in that cycle, so clr wins over simultaneous push/pop;
  - error detection is suppressed while clr=1.
- Outputs out_data and ram_din are pure pass-through with no registers.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, AF_MARGIN=1):
- Reset, then push 0x11 for one cycle -> ram_wen=1 with ram_addrin=0 that cycle. Next cycle out_valid=1, out_data=0x11, count=1.
- Push 0x00..0x07 back-to-back, no pops -> in_ready=0 after the 8th edge, count=8, almost_full=1 from count=7. Then in_valid=1 for one more cycle -> overflow=1, count stays 8.
- Drain all 8 with out_ready=1 -> out_data sequence 0x00..0x07, out_valid=0 after the last pop, count=0. Then out_ready=1 for one extra cycle -> underflow=1.
- 20 cycles of simultaneous push/pop at count=4, data incrementing from 0x40 -> count stays 4, in-order output. Pointers wrap past address 7 to 0 with no data loss.
- At full, assert in_valid and out_ready together -> pop occurs, push refused, count=7. Re-offered word is accepted next cycle and count returns to 8.
- With count=5 and overflow=1, assert clr while in_valid=out_ready=1 -> ram_wen=0 that cycle. Next cycle count=0, out_valid=0, overflow=0. Separately, drop rst_n mid-stream off the clock edge -> outputs return to reset values immediately.
